// File: rtl/qpsk_pkg.sv
// Shared types and lookup helpers for the QPSK modulator.
// Consumed by qpsk_mod_core and qpsk_symbol_mapper.
package qpsk_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic signed [15:0] AMP_DEFAULT = 16'sd23170;

  // Quadrant to {I negative, Q negative}: 0->(+,+) 1->(-,+) 2->(-,-) 3->(+,-)
  function automatic logic [1:0] quad_sign(input logic [1:0] quad);
    logic [1:0] sgn;
    case (quad)
      2'd0:    sgn = 2'b00;
      2'd1:    sgn = 2'b10;
      2'd2:    sgn = 2'b11;
      2'd3:    sgn = 2'b01;
      default: sgn = 2'b00;
    endcase
    return sgn;
  endfunction

  // Gray-ordered dibit to quadrant increment for differential encoding
  function automatic logic [1:0] dibit_inc(input logic [1:0] dibit);
    logic [1:0] inc;
    case (dibit)
      2'b00:   inc = 2'd0;
      2'b01:   inc = 2'd1;
      2'b11:   inc = 2'd2;
      2'b10:   inc = 2'd3;
      default: inc = 2'd0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// Combinational dibit/quadrant to {I,Q} constellation mapper.
// With QPSK_MOD_DIFF_ENC_EN, quad is the previous phase and the dibit advances it.
module qpsk_symbol_mapper
  import qpsk_pkg::*;
(
  input  logic [1:0]         dibit,
  input  logic signed [15:0] amp,
  input  logic [1:0]         quad,
  output logic [31:0]        iq
);

  logic [1:0]         neg_s;
  logic signed [15:0] amp_neg_s;

  assign amp_neg_s = -amp;

`ifdef QPSK_MOD_DIFF_ENC_EN
  assign neg_s = quad_sign(quad + dibit_inc(dibit));
`else
  // Direct mapping: quad acts as a fixed rotation, tied to 0 by the core
  assign neg_s = dibit ^ quad_sign(quad);
`endif

  assign iq = {(neg_s[1] ? amp_neg_s : amp), (neg_s[0] ? amp_neg_s : amp)};

endmodule

// File: rtl/qpsk_mod_core.sv
// QPSK modulator: packed dibits in, SPS-times held {I,Q} samples out.
// Optional differential encoding via QPSK_MOD_DIFF_ENC_EN.
module qpsk_mod_core
  import qpsk_pkg::*;
#(
  parameter int SPS    = 16,
  parameter int DIBITS = 16,
  parameter int CNT_W  = 4
) (
  input  logic               ce_clk,
  input  logic               ce_rst,
  input  logic               clear,
  input  logic signed [15:0] amp,
  input  logic [31:0]        i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [31:0]        o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic               busy
);

  localparam int SYM_W = $clog2(DIBITS);
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SPS - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(DIBITS - 1);

  state_t             state_r, state_nxt_s;
  logic [31:0]        shreg_r, shreg_nxt_s;
  logic [SYM_W-1:0]   sym_cnt_r, sym_nxt_s;
  logic [CNT_W-1:0]   smp_cnt_r, smp_nxt_s;
  logic               last_r, last_nxt_s;
  logic signed [15:0] amp_r, amp_nxt_s;
  logic [31:0]        tdata_r, tdata_nxt_s;
  logic               tlast_r, tlast_nxt_s;

  logic               hs_out_s, smp_end_s, word_done_s, load_s;
  logic [1:0]         map_dibit_s, base_quad_s;
  logic signed [15:0] map_amp_s;
  logic [31:0]        map_iq_s;

  assign hs_out_s    = (state_r == EMIT) && o_tready;
  assign smp_end_s   = (smp_cnt_r == SMP_LAST);
  assign word_done_s = hs_out_s && smp_end_s && (sym_cnt_r == SYM_LAST);
  assign i_tready    = !clear && ((state_r == IDLE) || word_done_s);
  assign load_s      = i_tready && i_tvalid;

  // shreg holds the upcoming dibit in [31:30]; the loaded word's first dibit maps straight from i_tdata
  assign map_dibit_s = load_s ? i_tdata[31:30] : shreg_r[31:30];
  assign map_amp_s   = load_s ? amp : amp_r;

`ifdef QPSK_MOD_DIFF_ENC_EN
  logic [1:0] quad_r, quad_nxt_s;

  assign base_quad_s = (word_done_s && last_r) ? 2'd0 : quad_r;

  // Phase accumulator: steps once per symbol start, zeroed after a packet ends
  always_comb begin
    quad_nxt_s = quad_r;
    if (clear) begin
      quad_nxt_s = 2'd0;
    end else if (load_s || (hs_out_s && smp_end_s && !word_done_s)) begin
      quad_nxt_s = base_quad_s + dibit_inc(map_dibit_s);
    end else begin
      quad_nxt_s = base_quad_s;
    end
  end

  // Phase register
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) quad_r <= 2'd0;
    else        quad_r <= quad_nxt_s;
  end
`else
  assign base_quad_s = 2'd0;
`endif

  qpsk_symbol_mapper u_mapper (
    .dibit (map_dibit_s),
    .amp   (map_amp_s),
    .quad  (base_quad_s),
    .iq    (map_iq_s)
  );

  // Next-state, counters and registered output data
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    sym_nxt_s   = sym_cnt_r;
    smp_nxt_s   = smp_cnt_r;
    last_nxt_s  = last_r;
    amp_nxt_s   = amp_r;
    tdata_nxt_s = tdata_r;
    if (clear) begin
      state_nxt_s = IDLE;
      shreg_nxt_s = 32'd0;
      sym_nxt_s   = '0;
      smp_nxt_s   = '0;
      last_nxt_s  = 1'b0;
      amp_nxt_s   = 16'sd0;
      tdata_nxt_s = 32'd0;
    end else if (load_s) begin
      state_nxt_s = EMIT;
      shreg_nxt_s = {i_tdata[29:0], 2'b00};
      sym_nxt_s   = '0;
      smp_nxt_s   = '0;
      last_nxt_s  = i_tlast;
      amp_nxt_s   = amp;
      tdata_nxt_s = map_iq_s;
    end else if (hs_out_s) begin
      if (word_done_s) begin
        state_nxt_s = IDLE;
        shreg_nxt_s = 32'd0;
        sym_nxt_s   = '0;
        smp_nxt_s   = '0;
        last_nxt_s  = 1'b0;
        tdata_nxt_s = 32'd0;
      end else if (smp_end_s) begin
        shreg_nxt_s = {shreg_r[29:0], 2'b00};
        sym_nxt_s   = sym_cnt_r + SYM_W'(1);
        smp_nxt_s   = '0;
        tdata_nxt_s = map_iq_s;
      end else begin
        smp_nxt_s   = smp_cnt_r + CNT_W'(1);
      end
    end else begin
      tdata_nxt_s = tdata_r;
    end
    tlast_nxt_s = last_nxt_s && (state_nxt_s == EMIT) &&
                  (sym_nxt_s == SYM_LAST) && (smp_nxt_s == SMP_LAST);
  end

  // State, datapath and output registers
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state_r   <= IDLE;
      shreg_r   <= 32'd0;
      sym_cnt_r <= '0;
      smp_cnt_r <= '0;
      last_r    <= 1'b0;
      amp_r     <= 16'sd0;
      tdata_r   <= 32'd0;
      tlast_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shreg_r   <= shreg_nxt_s;
      sym_cnt_r <= sym_nxt_s;
      smp_cnt_r <= smp_nxt_s;
      last_r    <= last_nxt_s;
      amp_r     <= amp_nxt_s;
      tdata_r   <= tdata_nxt_s;
      tlast_r   <= tlast_nxt_s;
    end
  end

  assign o_tdata  = tdata_r;
  assign o_tlast  = tlast_r;
  assign o_tvalid = (state_r == EMIT);
  assign busy     = (state_r != IDLE);

endmodule

// File: doc/qpsk_mod_core.md
Name: qpsk_mod_core

Overview:
Transmit-side counterpart of the QPSK receive chain (Costas loop plus bit sync) in the same RFNoC design.
- Accepts 32-bit AXI-stream words of packed payload bits.
- Maps each dibit to a QPSK constellation point and holds each symbol for SPS output samples (sample rate = 16 × symbol rate by default).
- Emits 32-bit {I,Q} AXI-stream samples with per-packet tlast.
- Sits between the axi_wrapper m_axis and s_axis data ports of a noc_block in the ce_clk domain.

Parameters:
- SPS, 16, samples per symbol; must be ≥ 1.
- DIBITS, 16, dibits per input word; fixed by the 32-bit input width.
- CNT_W, 4, width of the sample counter; must satisfy 2**CNT_W ≥ SPS.

Ports:
- ce_clk  in  1  block clock; all logic is on its rising edge.
- ce_rst  in  1  reset, asynchronous and active-high.
- clear  in  1  synchronous flush: returns to IDLE and drops the current word.
- amp  in  16  signed symbol amplitude; latched at word load. Typical value 23170 (0x5A82).
- i_tdata  in  32  payload bits; MSB dibit is transmitted first.
- i_tlast  in  1  marks the last word of a packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  32  {I[15:0], Q[15:0]}, both two's complement.
- o_tlast  out  1  last sample of a packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
Reset values (ce_rst, asynchronous), all zero:
- state = IDLE, o_tvalid, o_tlast, o_tdata, shift register, counters, busy.
- Differential phase quadrant = 0.

State machine:
- IDLE: i_tready = 1. On an i_tvalid handshake:
  - latch i_tdata into a 32-bit shift register; latch i_tlast and amp;
  - set sym_cnt = 0 and smp_cnt = 0;
  - go to EMIT.
- EMIT: o_tvalid = 1 and o_tdata = map(current dibit).
  - On each o_tready handshake, smp_cnt increments.
  - At smp_cnt = SPS-1: smp_cnt wraps to 0, the shift register shifts left 2 bits, and sym_cnt increments.
  - At sym_cnt = DIBITS-1 with smp_cnt = SPS-1, that handshake completes the word.

Output timing and handshake:
- o_tdata and o_tlast are registered outputs.
- The first sample is valid on the cycle after the input handshake.
- While o_tvalid = 1 and o_tready = 0, o_tdata and o_tlast hold stable (AXI rule).
- Back-to-back words: i_tready = 1 in EMIT during the word-completing handshake cycle.
  - If i_tvalid is also high, the next word loads in that cycle and the state stays EMIT with no bubble.
  - Otherwise the state goes to IDLE.
- o_tlast = 1 only on the word-completing sample of a word latched with tlast = 1.
- One input word produces exactly DIBITS × SPS samples (256 by default).

Mapping (non-differential): dibit b1b0.
- I = b1 ? -amp : +amp.
- Q = b0 ? -amp : +amp.
- Negation is two's complement; amp = -32768 is illegal (result undefined).

Boundary conditions:
- clear has priority over any handshake; the in-flight word is discarded and o_tvalid = 0 on the next cycle.
- ce_rst asserted mid-word forces all reset values immediately; no partial-packet tlast is generated.
- A change on amp during EMIT has no effect until the next word load.

Optional Feature:
Macro QPSK_MOD_DIFF_ENC_EN. Provides differential encoding to resolve the receiver Costas loop's 90° phase ambiguity.
- Defined:
  - Each dibit selects a quadrant increment: 00→0, 01→+1, 11→+2, 10→+3.
  - The increment is applied as p = p + inc mod 4, once per symbol at symbol start.
  - p maps to (I,Q) as: 0→(+,+), 1→(-,+), 2→(-,-), 3→(+,-).
  - p resets to 0 on ce_rst, on clear, and after a tlast word completes.
- Undefined: direct mapping as above; the p register is absent.

Decomposition:
- Package qpsk_pkg:
  - quadrant-to-sign table;
  - dibit-to-increment table;
  - default amplitude constant 16'sd23170;
  - state encoding localparams (IDLE, EMIT).
- One natural sub-module: qpsk_symbol_mapper. Combinational; inputs are dibit, amp and phase quadrant; output is the {I,Q} word.
- Counters, shift register and FSM stay in qpsk_mod_core.

Test Plan:
1. Word 0x00000000 with tlast, amp = 0x5A82, o_tready = 1 → 256 samples of 0x5A825A82; o_tlast only on sample 256; busy drops the cycle after it.
2. Word 0xC0000000, non-differential → 16 samples of 0xA57EA57E, then 240 samples of 0x5A825A82.
3. Two words presented back-to-back with i_tvalid held high → 512 contiguous samples, no o_tvalid gap, i_tready high only on cycles 0 and 256.
4. Random o_tready at 50% → o_tdata and o_tlast stable while stalled; sample count and order identical to the unstalled run.
5. ce_rst pulsed at sample 100, then clear tested separately at sample 100 → o_tvalid = 0 and busy = 0; the next word restarts cleanly from sample 0 with no tlast from the aborted word.
6. With QPSK_MOD_DIFF_ENC_EN, word 0x55000000 (dibits 01,01,01,01 then 00) → quadrants 1,2,3,0, giving 0xA57E5A82, 0xA57EA57E, 0x5A82A57E, then 0x5A825A82 held for the rest of the word.
